// File: rtl/fetch_unit.sv
// fetch_unit: PC holder, instruction fetch and load/store request sequencer.
// Ports: CLK/nRST clock and async active-low reset; ihit/iload instruction
// response; dhit data completion; halt/memread/memwrite/jump/jrsig/beq/bne/
// alu_zero/jump_addr/jr_addr/imm16 control-unit decodes; iREN/iaddr instruction
// request; instr/pc to control unit; dREN/dWEN data request; halted sticky
// halt flag; retired completed-instruction count.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        dhit,
  input  logic        halt,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        jump,
  input  logic        jrsig,
  input  logic        beq,
  input  logic        bne,
  input  logic        alu_zero,
  input  logic [31:0] jump_addr,
  input  logic [31:0] jr_addr,
  input  logic [15:0] imm16,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        dREN,
  output logic        dWEN,
  output logic        halted,
  output logic [31:0] retired
);
  typedef enum logic [1:0] {FETCH, MEM, HALTED} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ret_q, ret_d, pc4, npc;
  logic        taken;
  assign pc4   = pc_q + 32'd4;
  assign taken = (beq && alu_zero) || (bne && !alu_zero);
  assign npc   = jrsig ? {jr_addr[31:2], 2'b00} :
                 jump  ? jump_addr :
                 taken ? pc4 + {{14{imm16[15]}}, imm16, 2'b00} : pc4;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ret_d   = ret_q;
    if (state_q == FETCH && ihit) begin
      if (halt) begin
        state_d = HALTED;
        ret_d   = ret_q + 32'd1;
      end else if (memread || memwrite) begin
        instr_d = iload;
        state_d = MEM;
      end else begin
        pc_d  = npc;
        ret_d = ret_q + 32'd1;
      end
    end else if (state_q == MEM && dhit) begin
      pc_d    = npc;
      ret_d   = ret_q + 32'd1;
      state_d = FETCH;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ret_q   <= ret_d;
    end
  end
  // request strobes are gated with nRST so they drop the instant reset asserts
  assign iREN    = nRST && state_q == FETCH;
  assign dREN    = nRST && state_q == MEM && memread;
  assign dWEN    = nRST && state_q == MEM && memwrite;
  assign instr   = state_q == FETCH ? iload : instr_q;
  assign halted  = state_q == HALTED;
  assign pc      = pc_q;
  assign iaddr   = pc_q;
  assign retired = ret_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
module tb_fetch_unit;
  logic        CLK = 0, nRST, ihit, dhit, halt, memread, memwrite, jump, jrsig, beq, bne, alu_zero;
  logic [31:0] iload, jump_addr, jr_addr;
  logic [15:0] imm16;
  logic        iREN, dREN, dWEN, halted;
  logic [31:0] iaddr, instr, pc, retired;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] pc; logic [31:0] ret;} exp_t;
  exp_t sb[$];
  fetch_unit #(.PC_INIT(32'h0000_0100)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .dhit(dhit), .halt(halt),
    .memread(memread), .memwrite(memwrite), .jump(jump), .jrsig(jrsig), .beq(beq),
    .bne(bne), .alu_zero(alu_zero), .jump_addr(jump_addr), .jr_addr(jr_addr),
    .imm16(imm16), .iREN(iREN), .iaddr(iaddr), .instr(instr), .pc(pc),
    .dREN(dREN), .dWEN(dWEN), .halted(halted), .retired(retired)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [31:0] p, input logic [31:0] r);
    exp_t e;
    e.pc = p;
    e.ret = r;
    sb.push_back(e);
  endtask
  task automatic step();
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("iaddr", iaddr, e.pc);
      chk("retired", retired, e.ret);
    end
  endtask
  initial begin
    {nRST, ihit, dhit, halt, memread, memwrite, jump, jrsig, beq, bne, alu_zero} = '0;
    jump_addr = '0;
    jr_addr = '0;
    imm16 = '0;
    iload = 32'hDEAD_BEEF;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc", pc, 32'h100);
    chk("rst_iaddr", iaddr, 32'h100);
    chk("rst_retired", retired, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_iren", {31'b0, iREN}, 0);
    chk("rst_dren", {31'b0, dREN}, 0);
    chk("rst_dwen", {31'b0, dWEN}, 0);
    chk("rst_instr", instr, 32'hDEAD_BEEF);
    nRST = 1;
    ihit = 1;
    iload = 32'h0;
    #1;
    chk("run_iren", {31'b0, iREN}, 1);
    chk("run_iaddr0", iaddr, 32'h100);
    push(32'h104, 1); step();
    push(32'h108, 2); step();
    push(32'h10C, 3); step();
    jump = 1; jump_addr = 32'h200;
    push(32'h200, 4); step();
    jump = 0; beq = 1; imm16 = 16'hFFFE; alu_zero = 1;
    push(32'h1FC, 5); step();
    beq = 0; jump = 1;
    push(32'h200, 6); step();
    jump = 0; beq = 1; alu_zero = 0;
    push(32'h204, 7); step();
    beq = 0; bne = 1; imm16 = 16'h0004;
    push(32'h218, 8); step();
    bne = 0; jrsig = 1; jump = 1; jr_addr = 32'h1237; jump_addr = 32'h999;
    push(32'h1234, 9); step();
    jrsig = 0; ihit = 0; jump_addr = 32'h40;
    push(32'h1234, 9); step();
    ihit = 1;
    push(32'h40, 10); step();
    jump = 0; memread = 1; iload = 32'h8C22_0000;
    push(32'h40, 10); step();
    iload = 32'h1234_5678;
    #1;
    repeat (3) begin
      chk("lw_dren", {31'b0, dREN}, 1);
      chk("lw_dwen", {31'b0, dWEN}, 0);
      chk("lw_iren", {31'b0, iREN}, 0);
      chk("lw_instr", instr, 32'h8C22_0000);
      push(32'h40, 10); step();
    end
    dhit = 1;
    push(32'h44, 11); step();
    dhit = 0; memread = 0;
    #1;
    chk("lw_done_iren", {31'b0, iREN}, 1);
    chk("lw_done_dren", {31'b0, dREN}, 0);
    chk("lw_done_instr", instr, 32'h1234_5678);
    jump = 1; jump_addr = 32'h80;
    push(32'h80, 12); step();
    jump = 0; halt = 1;
    push(32'h80, 13); step();
    halt = 0;
    #1;
    chk("halt_flag", {31'b0, halted}, 1);
    chk("halt_iren", {31'b0, iREN}, 0);
    repeat (3) begin
      ihit = 1; dhit = 1; jump = 1; jump_addr = 32'h500; memread = 1;
      push(32'h80, 13); step();
      chk("halt_stay", {31'b0, halted}, 1);
      chk("halt_dren", {31'b0, dREN}, 0);
      chk("halt_iren2", {31'b0, iREN}, 0);
    end
    {ihit, dhit, jump, memread} = '0;
    nRST = 0;
    #1;
    chk("halt_rst_flag", {31'b0, halted}, 0);
    chk("halt_rst_pc", pc, 32'h100);
    chk("halt_rst_ret", retired, 0);
    nRST = 1;
    memwrite = 1; ihit = 1;
    push(32'h100, 0); step();
    ihit = 0;
    #1;
    chk("sw_dwen", {31'b0, dWEN}, 1);
    chk("sw_iren", {31'b0, iREN}, 0);
    #3;
    nRST = 0;
    #1;
    chk("sw_rst_dwen", {31'b0, dWEN}, 0);
    chk("sw_rst_pc", pc, 32'h100);
    chk("sw_rst_ret", retired, 0);
    chk("sw_rst_iren", {31'b0, iREN}, 0);
    @(posedge CLK);
    #1;
    nRST = 1;
    #1;
    chk("sw_fetch_iren", {31'b0, iREN}, 1);
    chk("sw_fetch_dwen", {31'b0, dWEN}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
